lap_recorder: RTL and testbench

LAP_RECORDER -- requirements
Module: lap_recorder

---
 rtl/lap_recorder_pkg.sv | 10 +
 rtl/lap_recorder_edge_rise.sv | 24 ++
 rtl/lap_recorder.sv | 93 +++++++++
 tb/tb_lap_recorder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lap_recorder_pkg.sv
// Shared definitions for the lap recorder: default depth, time bundle width, state encoding.
package lap_recorder_pkg;
    localparam int DEPTH_DEF = 8;
    localparam int TIME_W    = 32;

    typedef enum logic {
        LIVE   = 1'b0,
        RECALL = 1'b1
    } state_t;
endpackage

// File: rtl/lap_recorder_edge_rise.sv
// Rising-edge detector for a debounced button level.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulse
);
    logic prev;
    logic armed;

    // armed stays low for the first cycle after reset so a button held
    // across reset release loads prev without producing an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= in;
            armed <= 1'b1;
        end
    end

    assign pulse = in & ~prev & armed;
endmodule

// File: rtl/lap_recorder.sv
// Stopwatch lap store: captures live BCD time on lap presses and replays stored laps in recall.
//   state  | meaning
//   LIVE   | display follows live time, lap presses capture
//   RECALL | display shows stored slot lap_idx, next steps through laps
module lap_recorder
    import lap_recorder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               hours,
    input  logic [7:0]               minutes,
    input  logic [7:0]               seconds,
    input  logic [7:0]               centisec,
    input  logic                     lap,
    input  logic                     recall,
    input  logic                     next,
    input  logic                     clear,
    output logic [7:0]               disp_hours,
    output logic [7:0]               disp_minutes,
    output logic [7:0]               disp_seconds,
    output logic [7:0]               disp_centisec,
    output logic [$clog2(DEPTH):0]   lap_count,
    output logic [$clog2(DEPTH)-1:0] lap_idx,
    output logic                     recall_active,
    output logic                     full
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic lap_p, rec_p, nxt_p, clr_p;
    logic rec_take, lap_take;
    state_t state, state_nxt;
    logic [TIME_W-1:0] slots [DEPTH];
    logic [TIME_W-1:0] live_time, disp_d, disp_q;

    edge_rise u_lap (.clk(clk), .rst_n(rst_n), .in(lap),    .pulse(lap_p));
    edge_rise u_rec (.clk(clk), .rst_n(rst_n), .in(recall), .pulse(rec_p));
    edge_rise u_nxt (.clk(clk), .rst_n(rst_n), .in(next),   .pulse(nxt_p));
    edge_rise u_clr (.clk(clk), .rst_n(rst_n), .in(clear),  .pulse(clr_p));

    assign live_time = {hours, minutes, seconds, centisec};
    assign full      = (lap_count == CNT_W'(DEPTH));

    // Priority clear > recall > next > lap; a recall press with an empty store is a no-op.
    assign rec_take = rec_p && !clr_p && (state == RECALL || lap_count != '0);
    assign lap_take = lap_p && !clr_p && !rec_take && (state == LIVE) && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LIVE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr_p)
            state_nxt = LIVE;
        else if (rec_take)
            state_nxt = (state == LIVE) ? RECALL : LIVE;
    end

    always_comb begin
        recall_active = (state == RECALL);
        disp_d        = (state == RECALL) ? slots[lap_idx] : live_time;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_count <= '0;
            lap_idx   <= '0;
            disp_q    <= '0;
        end else begin
            disp_q <= disp_d;
            if (clr_p) begin
                lap_count <= '0;
                lap_idx   <= '0;
            end else if (rec_take) begin
                lap_idx <= '0;
            end else if (state == RECALL && nxt_p) begin
                lap_idx <= (CNT_W'(lap_idx) == lap_count - CNT_W'(1)) ? '0 : lap_idx + IDX_W'(1);
            end else if (lap_take) begin
                lap_count <= lap_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (lap_take) slots[lap_count[IDX_W-1:0]] <= live_time;
    end

    assign {disp_hours, disp_minutes, disp_seconds, disp_centisec} = disp_q;
endmodule

// File: tb/tb_lap_recorder.sv
// Self-checking bench for lap_recorder against a behavioural lap-store model.
module tb_lap_recorder;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] hours = 8'h00, minutes = 8'h00, seconds = 8'h00, centisec = 8'h00;
    logic lap = 1'b0, recall = 1'b0, next = 1'b0, clear = 1'b0;
    logic [7:0] disp_hours, disp_minutes, disp_seconds, disp_centisec;
    logic [3:0] lap_count;
    logic [2:0] lap_idx;
    logic recall_active, full;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_laps [DEPTH];
    int m_count = 0;
    int m_idx = 0;
    bit m_recall = 1'b0;

    lap_recorder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .hours(hours), .minutes(minutes), .seconds(seconds), .centisec(centisec),
        .lap(lap), .recall(recall), .next(next), .clear(clear),
        .disp_hours(disp_hours), .disp_minutes(disp_minutes),
        .disp_seconds(disp_seconds), .disp_centisec(disp_centisec),
        .lap_count(lap_count), .lap_idx(lap_idx),
        .recall_active(recall_active), .full(full)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rand_bcd(int maxv);
        int v = $urandom_range(maxv, 0);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [31:0] cur_time();
        return {hours, minutes, seconds, centisec};
    endfunction

    function automatic logic [31:0] disp_now();
        return {disp_hours, disp_minutes, disp_seconds, disp_centisec};
    endfunction

    function automatic logic [31:0] exp_disp();
        return m_recall ? m_laps[m_idx] : cur_time();
    endfunction

    task automatic set_time(logic [31:0] t);
        {hours, minutes, seconds, centisec} = t;
    endtask

    task automatic rand_time();
        set_time({rand_bcd(23), rand_bcd(59), rand_bcd(59), rand_bcd(99)});
    endtask

    // Reference behaviour of one set of simultaneous button presses.
    function automatic void model_edge(bit c, bit r, bit n, bit l);
        if (c) begin
            m_count = 0; m_idx = 0; m_recall = 1'b0;
        end else if (!m_recall) begin
            if (r && m_count > 0) begin
                m_recall = 1'b1; m_idx = 0;
            end else if (l && m_count < DEPTH) begin
                m_laps[m_count] = cur_time();
                m_count++;
            end
        end else begin
            if (r) begin
                m_recall = 1'b0; m_idx = 0;
            end else if (n) begin
                m_idx = (m_idx + 1) % m_count;
            end
        end
    endfunction

    task automatic press(bit c, bit r, bit n, bit l);
        @(negedge clk);
        {clear, recall, next, lap} = {c, r, n, l};
        model_edge(c, r, n, l);
        @(negedge clk);
        {clear, recall, next, lap} = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rand_time();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({disp_now(), lap_count, lap_idx, full, recall_active} !== '0) begin
            fails++;
            $display("FAIL reset_state: got disp=%h cnt=%0d idx=%0d full=%b rec=%b, required all 0",
                     disp_now(), lap_count, lap_idx, full, recall_active);
        end
        m_count = 0; m_idx = 0; m_recall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_live();
        logic [31:0] prev_t, new_t;
        set_time(32'h01020304);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (lap_count !== 4'd1) begin
            fails++; $display("FAIL live_lap_count: got %0d, required 1", lap_count);
        end
        tests++;
        if (disp_now() !== 32'h01020304) begin
            fails++; $display("FAIL live_disp: got %h, required 01020304", disp_now());
        end
        for (int i = 0; i < 4; i++) begin
            prev_t = cur_time();
            @(negedge clk);
            rand_time();
            new_t = cur_time();
            #1;
            tests++;
            if (disp_now() !== prev_t) begin
                fails++; $display("FAIL live_delay_old: got %h, required %h", disp_now(), prev_t);
            end
            @(posedge clk);
            #1;
            tests++;
            if (disp_now() !== new_t) begin
                fails++; $display("FAIL live_delay_new: got %h, required %h", disp_now(), new_t);
            end
        end
    endtask

    task automatic test_recall_walk();
        logic [31:0] tbl [3];
        tbl[0] = 32'h00000100; tbl[1] = 32'h00000250; tbl[2] = 32'h00000799;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_time(tbl[i]);
            press(1'b0, 1'b0, 1'b0, 1'b1);
        end
        rand_time();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (recall_active !== 1'b1 || lap_idx !== 3'd0 || disp_now() !== tbl[0]) begin
            fails++;
            $display("FAIL recall_enter: got rec=%b idx=%0d disp=%h, required rec=1 idx=0 disp=%h",
                     recall_active, lap_idx, disp_now(), tbl[0]);
        end
        for (int k = 1; k <= 3; k++) begin
            press(1'b0, 1'b0, 1'b1, 1'b0);
            tests++;
            if (lap_idx !== 3'(k % 3) || disp_now() !== tbl[k % 3]) begin
                fails++;
                $display("FAIL recall_next%0d: got idx=%0d disp=%h, required idx=%0d disp=%h",
                         k, lap_idx, disp_now(), k % 3, tbl[k % 3]);
            end
        end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (recall_active !== 1'b0 || disp_now() !== cur_time()) begin
            fails++;
            $display("FAIL recall_exit: got rec=%b disp=%h, required rec=0 disp=%h",
                     recall_active, disp_now(), cur_time());
        end
    endtask

    task automatic test_full();
        logic [31:0] last_kept;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            rand_time();
            if (i == DEPTH - 1) last_kept = cur_time();
            press(1'b0, 1'b0, 1'b0, 1'b1);
            if (i == DEPTH - 2) begin
                tests++;
                if (full !== 1'b0 || lap_count !== 4'(DEPTH - 1)) begin
                    fails++;
                    $display("FAIL full_early: got full=%b cnt=%0d, required full=0 cnt=%0d",
                             full, lap_count, DEPTH - 1);
                end
            end
        end
        tests++;
        if (full !== 1'b1 || lap_count !== 4'(DEPTH)) begin
            fails++;
            $display("FAIL full_count: got full=%b cnt=%0d, required full=1 cnt=%0d",
                     full, lap_count, DEPTH);
        end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) press(1'b0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (lap_idx !== 3'(DEPTH - 1) || disp_now() !== last_kept) begin
            fails++;
            $display("FAIL full_last_slot: got idx=%0d disp=%h, required idx=%0d disp=%h",
                     lap_idx, disp_now(), DEPTH - 1, last_kept);
        end
        press(1'b0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (lap_idx !== 3'd0) begin
            fails++; $display("FAIL full_wrap: got idx=%0d, required 0", lap_idx);
        end
        press(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_empty();
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (recall_active !== 1'b0 || lap_count !== 4'd0) begin
            fails++;
            $display("FAIL empty_recall: got rec=%b cnt=%0d, required rec=0 cnt=0",
                     recall_active, lap_count);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0, 1'b1);
        tests++;
        if (lap_count !== 4'd0 || full !== 1'b0) begin
            fails++;
            $display("FAIL clear_vs_lap: got cnt=%0d full=%b, required cnt=0 full=0", lap_count, full);
        end
    endtask

    task automatic test_recall_next_same();
        press(1'b1, 1'b0, 1'b0, 1'b0);
        rand_time(); press(1'b0, 1'b0, 1'b0, 1'b1);
        rand_time(); press(1'b0, 1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b1, 1'b0);
        tests++;
        if (recall_active !== 1'b0 || lap_idx !== 3'd0) begin
            fails++;
            $display("FAIL recall_over_next: got rec=%b idx=%0d, required rec=0 idx=0",
                     recall_active, lap_idx);
        end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        rand_time();
        press(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (lap_count !== 4'd2 || recall_active !== 1'b1 || disp_now() !== m_laps[0]) begin
            fails++;
            $display("FAIL lap_in_recall: got cnt=%0d rec=%b disp=%h, required cnt=2 rec=1 disp=%h",
                     lap_count, recall_active, disp_now(), m_laps[0]);
        end
        press(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        bit c, r, n, l;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 80; i++) begin
            rand_time();
            c = ($urandom_range(11, 0) == 0);
            r = ($urandom_range(4, 0) == 0);
            n = ($urandom_range(2, 0) == 0);
            l = ($urandom_range(1, 0) == 0);
            press(c, r, n, l);
            tests++;
            if (lap_count !== 4'(m_count) || lap_idx !== 3'(m_idx) || recall_active !== m_recall
                || full !== (m_count == DEPTH) || disp_now() !== exp_disp()) begin
                fails++;
                $display("FAIL random_step%0d: got cnt=%0d idx=%0d rec=%b full=%b disp=%h, required cnt=%0d idx=%0d rec=%b full=%b disp=%h",
                         i, lap_count, lap_idx, recall_active, full, disp_now(),
                         m_count, m_idx, m_recall, m_count == DEPTH, exp_disp());
            end
        end
    endtask

    task automatic test_reset_mid_recall();
        press(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rand_time(); press(1'b0, 1'b0, 1'b0, 1'b1);
        end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        lap = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({disp_now(), lap_count, lap_idx, full, recall_active} !== '0) begin
            fails++;
            $display("FAIL reset_async: got disp=%h cnt=%0d idx=%0d full=%b rec=%b, required all 0",
                     disp_now(), lap_count, lap_idx, full, recall_active);
        end
        m_count = 0; m_idx = 0; m_recall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (lap_count !== 4'd0 || recall_active !== 1'b0) begin
            fails++;
            $display("FAIL held_lap_after_reset: got cnt=%0d rec=%b, required cnt=0 rec=0",
                     lap_count, recall_active);
        end
        lap = 1'b0;
        rand_time();
        press(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (lap_count !== 4'd1 || disp_now() !== cur_time()) begin
            fails++;
            $display("FAIL lap_after_release: got cnt=%0d disp=%h, required cnt=1 disp=%h",
                     lap_count, disp_now(), cur_time());
        end
    endtask

    initial begin
        test_reset();
        test_live();
        test_recall_walk();
        test_full();
        test_empty();
        test_recall_next_same();
        test_random();
        test_reset_mid_recall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
